// File: rtl/design_compare_monitor.sv
// rtl/design_compare_monitor.sv - golden-vs-netlist output compare monitor
// Counts matches/mismatches over a run and latches the operands of the first mismatch.
module design_compare_monitor #(
    parameter int WIDTH   = 32,
    parameter int SETTLE  = 2,
    parameter int NUM_VEC = 1000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] dut,
    output logic             busy,
    output logic             cmp_strobe,
    output logic             fail,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_golden,
    output logic [WIDTH-1:0] first_dut
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SETTLE, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [31:0]      NUM_VEC_U = NUM_VEC;
    localparam bit               ONE_CYCLE = (SETTLE == 1);

    state_t         state;
    logic [3:0]     settle_cnt;
    logic [1:0]     rst_sync;
    logic           rst_ok;
    logic           mismatch;
    logic           fire;
    logic           last;
    logic [CNT_W-1:0] match_nxt;
    logic [CNT_W-1:0] mis_nxt;
    logic [CNT_W:0]   total_cur;
    logic [CNT_W:0]   total_nxt;

    // Deassertion of rst reaches the FSM only after two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok = rst_sync[1];

    always_comb begin
        mismatch  = (golden != dut);
        // Counter value 1 means the comparison executes on this edge.
        fire      = (state == S_SETTLE && settle_cnt == 4'd1) ||
                    (state == S_ARMED && stim_valid && ONE_CYCLE);
        match_nxt = (!mismatch && match_cnt != CNT_MAX) ? match_cnt + 1'b1 : match_cnt;
        mis_nxt   = (mismatch && mismatch_cnt != CNT_MAX) ? mismatch_cnt + 1'b1 : mismatch_cnt;
        total_cur = {1'b0, match_cnt} + {1'b0, mismatch_cnt};
        total_nxt = {1'b0, match_nxt} + {1'b0, mis_nxt};
        last      = (32'(total_nxt) == NUM_VEC_U);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            cmp_strobe   <= 1'b0;
            fail         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_golden <= '0;
            first_dut    <= '0;
        end else begin
            cmp_strobe <= 1'b0;
            if (start && rst_ok) begin
                state        <= S_ARMED;
                settle_cnt   <= '0;
                busy         <= 1'b1;
                fail         <= 1'b0;
                done         <= 1'b0;
                pass         <= 1'b0;
                match_cnt    <= '0;
                mismatch_cnt <= '0;
                first_idx    <= '0;
                first_golden <= '0;
                first_dut    <= '0;
            end else if (state == S_ARMED || state == S_SETTLE) begin
                if (fire) begin
                    cmp_strobe   <= 1'b1;
                    match_cnt    <= match_nxt;
                    mismatch_cnt <= mis_nxt;
                    if (mismatch && !fail) begin
                        first_idx    <= (total_cur > {1'b0, CNT_MAX}) ? CNT_MAX
                                                                      : total_cur[CNT_W-1:0];
                        first_golden <= golden;
                        first_dut    <= dut;
                    end
                    if (mismatch) fail <= 1'b1;
                end
                if (fire && last) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (mis_nxt == '0);
                end else if (stim_valid && !ONE_CYCLE) begin
                    // A new stimulus restarts the settle window; an unfinished one is dropped.
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LD;
                end else if (fire) begin
                    state <= S_ARMED;
                end else if (state == S_SETTLE) begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_design_compare_monitor.sv
// tb/tb_design_compare_monitor.sv - scoreboard bench for design_compare_monitor
// Deadline-based reference model feeds an expectation queue drained by a strobe monitor.
module tb_design_compare_monitor;

    localparam int WIDTH   = 32;
    localparam int SETTLE  = 3;
    localparam int NUM_VEC = 20;
    localparam int CNT_W   = 4;
    localparam int CMAX    = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stim_valid = 1'b0;
    logic [WIDTH-1:0] golden = '0;
    logic [WIDTH-1:0] dut = '0;
    logic             busy, cmp_strobe, fail, done, pass;
    logic [CNT_W-1:0] match_cnt, mismatch_cnt, first_idx;
    logic [WIDTH-1:0] first_golden, first_dut;

    design_compare_monitor #(
        .WIDTH(WIDTH), .SETTLE(SETTLE), .NUM_VEC(NUM_VEC), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid),
        .golden(golden), .dut(dut), .busy(busy), .cmp_strobe(cmp_strobe),
        .fail(fail), .done(done), .pass(pass), .match_cnt(match_cnt),
        .mismatch_cnt(mismatch_cnt), .first_idx(first_idx),
        .first_golden(first_golden), .first_dut(first_dut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          mc;
        int          xc;
        int          fi;
        logic        fl;
        logic        dn;
        logic [31:0] fg;
        logic [31:0] fd;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int          m_match, m_mis, m_fi, pend;
    logic        m_fail, m_done, m_run;
    logic [31:0] m_fg, m_fd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_match = 0; m_mis = 0; m_fi = 0; m_fail = 0; m_done = 0;
        m_fg = '0; m_fd = '0; pend = -1;
    endtask

    // Each comparison lands on the cycle SETTLE after its stimulus, sampling the
    // operands present in the cycle just before; a newer stimulus supersedes a pending one.
    task automatic model_step();
        exp_t e;
        if (!rst) return;
        if (start) begin
            model_clear();
            m_run = 1;
        end else if (m_run) begin
            if (pend == cyc + 1) begin
                pend = -1;
                if (golden != dut) begin
                    if (!m_fail) begin
                        m_fi = (m_match + m_mis > CMAX) ? CMAX : m_match + m_mis;
                        m_fg = golden;
                        m_fd = dut;
                    end
                    m_fail = 1;
                    if (m_mis < CMAX) m_mis++;
                end else if (m_match < CMAX) begin
                    m_match++;
                end
                if (m_match + m_mis == NUM_VEC) begin
                    m_done = 1;
                    m_run  = 0;
                end
                e = '{at: cyc + 1, mc: m_match, xc: m_mis, fi: m_fi, fl: m_fail,
                      dn: m_done, fg: m_fg, fd: m_fd};
                q.push_back(e);
            end
            if (m_run && stim_valid) pend = cyc + SETTLE;
        end
    endtask

    task automatic tick(input logic s, input logic v, input logic [31:0] g, input logic [31:0] d);
        @(posedge clk);
        #1;
        start = s; stim_valid = v; golden = g; dut = d;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, golden, dut);
    endtask

    task automatic vec(input logic [31:0] g, input logic [31:0] d, input int gap);
        tick(1'b0, 1'b1, g, d);
        idle(gap - 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, {busy, cmp_strobe, fail, done, pass}, 0);
        chk({tag, "_cnts"}, {match_cnt, mismatch_cnt, first_idx}, 0);
        chk({tag, "_capture"}, {first_golden, first_dut}, 0);
    endtask

    // Monitor: every strobe must match the head of the queue, and no expectation may be missed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                chk("missing_strobe", 0, e.at);
            end
            if (cmp_strobe) begin
                if (q.size() == 0 || q[0].at != cyc) begin
                    chk("unexpected_strobe", cyc, (q.size() == 0) ? 0 : q[0].at);
                end else begin
                    e = q.pop_front();
                    chk("match_cnt", match_cnt, e.mc);
                    chk("mismatch_cnt", mismatch_cnt, e.xc);
                    chk("fail_done", {fail, done}, {e.fl, e.dn});
                    chk("first_idx", first_idx, e.fi);
                    chk("first_ops", {first_golden, first_dut}, {e.fg, e.fd});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] g, d;
        int guard;
        m_run = 0;
        model_clear();

        idle(2);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b1;
        idle(3);
        check_zero("post_reset_idle");

        // Run A: three clean vectors, then a collapsed pair and a back-to-back overlap
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) vec(32'h0000_00A5, 32'h0000_00A5, 4);
        idle(4);
        chk("run_a_match", match_cnt, 3);
        chk("run_a_fail", fail, 0);
        chk("run_a_busy", busy, 1);
        vec(32'h1111_1111, 32'h1111_1111, 1);
        vec(32'h2222_2222, 32'h2222_2222, 5);
        vec(32'h3333_3333, 32'h3333_3333, SETTLE - 1);
        vec(32'h4444_4444, 32'h4444_4444, 6);
        chk("run_a_after_pairs", match_cnt, m_match);

        // Run B: abort and restart; mismatches at indices 2 and 3, then random to completion
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        vec(32'h0000_00A5, 32'h0000_00A5, 4);
        vec(32'h0000_00A5, 32'h0000_00A5, 4);
        vec(32'h1234_5678, 32'h1234_5679, 4);
        vec(32'hDEAD_BEEF, 32'hDEAD_0000, 4);
        guard = 0;
        while (!m_done && guard < 300) begin
            g = $urandom;
            d = ($urandom_range(0, 3) == 0) ? (g ^ (32'h1 << $urandom_range(0, 31))) : g;
            vec(g, d, $urandom_range(1, 6));
            guard++;
        end
        idle(SETTLE + 3);
        chk("run_b_done", done, 1);
        chk("run_b_busy", busy, 0);
        chk("run_b_pass", pass, 0);
        chk("run_b_first_idx", first_idx, 2);
        chk("run_b_first_golden", first_golden, 32'h1234_5678);
        chk("run_b_first_dut", first_dut, 32'h1234_5679);
        chk("run_b_mismatches", mismatch_cnt, m_mis);
        for (int i = 0; i < 3; i++) vec(32'h5, 32'h6, 4);
        chk("done_ignores_stim", {match_cnt, mismatch_cnt}, {4'(m_match), 4'(m_mis)});

        // Reset while a comparison is settling
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        vec(32'h7, 32'h8, 2);
        @(posedge clk);
        #1 rst = 1'b0;
        m_run = 0;
        model_clear();
        q.delete();
        #1;
        check_zero("async_reset");
        idle(2);
        @(posedge clk); #1 rst = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) vec(32'h9, 32'hA, 4);
        chk("no_run_without_start", {busy, match_cnt, mismatch_cnt}, 0);

        // Saturation: 20 forced mismatches on a 4-bit counter
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) vec(32'(i), ~32'(i), 4);
        idle(SETTLE + 2);
        chk("sat_mismatch", mismatch_cnt, CMAX);
        chk("sat_busy_done", {busy, done, fail}, 3'b101);

        idle(5);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/design_compare_monitor.md
DESIGN_COMPARE_MONITOR -- requirements
Module: design_compare_monitor

Interface
REQ-001 Parameter WIDTH, default 32, width of the compared output vectors.
REQ-002 Parameter SETTLE, default 2, cycles between a stimulus strobe and its comparison; legal range 1..15.
REQ-003 Parameter NUM_VEC, default 1000, number of comparisons in a run; legal range 1..65535.
REQ-004 Parameter CNT_W, default 16, width of all counters.
REQ-005 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  one-cycle pulse that arms a new run.
REQ-008 Port stim_valid  input  1  one-cycle pulse marking that a new stimulus was applied this cycle.
REQ-009 Port golden  input  WIDTH  output of the reference model.
REQ-010 Port dut  input  WIDTH  output of the post-route netlist.
REQ-011 Port busy  output  1  high while a run is armed and not finished.
REQ-012 Port cmp_strobe  output  1  one-cycle pulse on every executed comparison.
REQ-013 Port fail  output  1  sticky; high once any comparison in the run mismatches.
REQ-014 Port done  output  1  sticky; high after NUM_VEC comparisons.
REQ-015 Port pass  output  1  done AND mismatch_cnt==0; valid only while done is high.
REQ-016 Port match_cnt, mismatch_cnt  output  CNT_W each  comparison tallies.
REQ-017 Port first_idx  output  CNT_W  index (0-based) of the first mismatching comparison.
REQ-018 Port first_golden, first_dut  output  WIDTH each  operands captured at the first mismatch.

Function
REQ-019 The FSM SHALL have four states: IDLE, ARMED, SETTLE, DONE.
REQ-020 IDLE -> ARMED on start; this transition SHALL clear all counters, fail, done and the capture registers.
REQ-021 ARMED -> SETTLE on stim_valid, with the settle counter loaded to SETTLE-1.
REQ-022 In SETTLE the counter SHALL decrement each cycle; at zero, one comparison executes and the FSM returns to ARMED.
REQ-023 The total latency from stim_valid to cmp_strobe SHALL be exactly SETTLE cycles; for example, stim_valid in cycle t gives a strobe in cycle t+2 for the default.
REQ-024 A comparison SHALL register golden and dut at the executing edge, using a full WIDTH-bit inequality test.
REQ-025 On a match, match_cnt SHALL increment by 1.
REQ-026 On a mismatch, mismatch_cnt SHALL increment by 1 and fail SHALL set.
REQ-027 On the first mismatch only, first_idx, first_golden and first_dut SHALL load; they SHALL hold for the rest of the run.
REQ-028 stim_valid in SETTLE SHALL reload the counter to SETTLE-1 and drop the pending comparison; no strobe and no count change result.
REQ-029 stim_valid in the same cycle as an executing comparison SHALL let that comparison complete and then enter SETTLE, not ARMED.
REQ-030 When match_cnt+mismatch_cnt reaches NUM_VEC, the FSM SHALL enter DONE on the next edge and set done; busy SHALL be low in DONE and IDLE.
REQ-031 In DONE, stim_valid SHALL be ignored and start SHALL behave as in REQ-020.
REQ-032 start in ARMED or SETTLE SHALL abort the run and re-arm with all state cleared.
REQ-033 Counters SHALL saturate at all-ones and never wrap.
REQ-034 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-035 Asserting rst low SHALL immediately force IDLE and drive every output to 0, including counters and capture registers.
REQ-036 Reset asserted mid-run SHALL discard the run; after rst is released, the block SHALL wait for start.
REQ-037 rst deassertion SHALL be synchronised internally through two flops before the FSM leaves IDLE.

Verification
REQ-038 Stimulus: start, then 3 stim_valid pulses spaced 4 cycles apart, with golden==dut==32'h0000_00A5. Response: 3 cmp_strobe pulses, each SETTLE cycles after its stim_valid; match_cnt=3, fail=0.
REQ-039 Stimulus: NUM_VEC=4; vector 2 has golden=32'h1234_5678 and dut=32'h1234_5679. Response: mismatch_cnt=1, first_idx=2, first_dut=32'h1234_5679, done=1, pass=0.
REQ-040 Stimulus: a second mismatch at index 3 with different values. Response: the first_* registers still hold the index-2 values; mismatch_cnt=2.
REQ-041 Stimulus: stim_valid, then another stim_valid one cycle later. Response: exactly one cmp_strobe, SETTLE cycles after the second pulse.
REQ-042 Stimulus: rst pulsed low during SETTLE. Response: all outputs 0 in the same cycle; no strobe follows; stim_valid is ignored until start.
REQ-043 Stimulus: CNT_W=4 with 20 forced mismatches. Response: mismatch_cnt saturates at 15, with no wrap.
